// File: rtl/ode_step_sequencer_if.sv
// Handshake bundle between the ODE step sequencer and the controller, Euler step
// module and interpolator it coordinates.
interface ode_step_sequencer_if #(
  parameter int STEP_CNT_WIDTH = 16
);
  logic                      Process;
  logic                      INT;
  logic [STEP_CNT_WIDTH-1:0] Num_Steps;
  logic                      Euler_Enable;
  logic                      Euler_End;
  logic                      Error_Flag;
  logic                      Chage_State;
  logic                      Change_State_End;
  logic                      Done_Processing;
  logic                      Busy;
  logic                      Fault;
  logic [STEP_CNT_WIDTH-1:0] Step_Count;
  logic [3:0]                Retry_Count;

  modport master (
    output Process, INT, Num_Steps, Euler_End, Error_Flag, Change_State_End,
    input  Euler_Enable, Chage_State, Done_Processing, Busy, Fault,
           Step_Count, Retry_Count
  );

  modport slave (
    input  Process, INT, Num_Steps, Euler_End, Error_Flag, Change_State_End,
    output Euler_Enable, Chage_State, Done_Processing, Busy, Fault,
           Step_Count, Retry_Count
  );
endinterface

// File: rtl/ode_step_sequencer.sv
// Sequences Euler attempts and interpolator updates for a fixed number of accepted
// ODE steps, with retry limiting, wait timeouts and an abort/clear request.
module ode_step_sequencer #(
  parameter int STEP_CNT_WIDTH = 16,
  parameter int MAX_RETRY      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ode_step_sequencer_if.slave seq_if
);

  localparam int                TMR_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]        RETRY_LIMIT = 4'(MAX_RETRY);
  localparam logic [TMR_W-1:0]  TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, E_START, E_WAIT, I_START, I_WAIT, DONE, FAULT
  } state_e;

  state_e                    state_q, state_d;
  logic [STEP_CNT_WIDTH-1:0] num_steps_q, num_steps_d;
  logic [STEP_CNT_WIDTH-1:0] step_q, step_d;
  logic [3:0]                retry_q, retry_d;
  logic [TMR_W-1:0]          tmr_q, tmr_d;
  logic                      euler_en_q, chg_state_q, done_q, busy_q, fault_q;

  always_comb begin
    state_d     = state_q;
    num_steps_d = num_steps_q;
    step_d      = step_q;
    retry_d     = retry_q;
    tmr_d       = tmr_q;

    // Abort outranks every other event and leaves the counters untouched.
    if (seq_if.INT) begin
      if (state_q != IDLE) state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (seq_if.Process) begin
            num_steps_d = seq_if.Num_Steps;
            step_d      = '0;
            retry_d     = '0;
            state_d     = (seq_if.Num_Steps != '0) ? E_START : DONE;
          end
        end
        E_START: begin
          tmr_d   = '0;
          state_d = E_WAIT;
        end
        E_WAIT: begin
          if (seq_if.Euler_End) begin
            if (seq_if.Error_Flag) begin
              retry_d = retry_q + 4'd1;
              state_d = (retry_d == RETRY_LIMIT) ? FAULT : E_START;
            end else begin
              state_d = I_START;
            end
          end else if (tmr_q == TMR_LAST) begin
            state_d = FAULT;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        I_START: begin
          tmr_d   = '0;
          state_d = I_WAIT;
        end
        I_WAIT: begin
          if (seq_if.Change_State_End) begin
            step_d  = step_q + 1'b1;
            retry_d = '0;
            state_d = (step_d == num_steps_q) ? DONE : E_START;
          end else if (tmr_q == TMR_LAST) begin
            state_d = FAULT;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so each pulse lines up with its state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      num_steps_q <= '0;
      step_q      <= '0;
      retry_q     <= '0;
      tmr_q       <= '0;
      euler_en_q  <= 1'b0;
      chg_state_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_steps_q <= num_steps_d;
      step_q      <= step_d;
      retry_q     <= retry_d;
      tmr_q       <= tmr_d;
      euler_en_q  <= (state_d == E_START);
      chg_state_q <= (state_d == I_START);
      done_q      <= (state_d == DONE);
      busy_q      <= (state_d != IDLE) && (state_d != FAULT);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign seq_if.Euler_Enable    = euler_en_q;
  assign seq_if.Chage_State     = chg_state_q;
  assign seq_if.Done_Processing = done_q;
  assign seq_if.Busy            = busy_q;
  assign seq_if.Fault           = fault_q;
  assign seq_if.Step_Count      = step_q;
  assign seq_if.Retry_Count     = retry_q;

endmodule
